// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns received bytes into an object position that is
// published to the renderer only on frame_start, so the sprite never tears.
// Ports: clk, reset (sync, active-high), rx_data/rx_valid (byte strobe),
//   frame_start (vblank pulse), obj_x/obj_y (displayed position),
//   busy (packet in progress), cmd_err (one-cycle packet timeout pulse).
// Build option: define CMD_CLAMP_EN to saturate moves and absolute loads at
//   X_MAX/Y_MAX; without it moves wrap modulo 1024 and loads are raw.
module uart_cmd_decoder #(
  parameter int STEP    = 4,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int X_MAX   = 539,
  parameter int Y_MAX   = 379,
  parameter int TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       frame_start,
  output logic [9:0] obj_x,
  output logic [9:0] obj_y,
  output logic       busy,
  output logic       cmd_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LP_TMO = CW'(TIMEOUT - 1);
  localparam logic [9:0] LP_STEP = 10'(STEP);
  localparam logic [9:0] LP_XI = 10'(X_INIT);
  localparam logic [9:0] LP_YI = 10'(Y_INIT);

  if (X_MAX > 1023 || Y_MAX > 1023 || STEP > 1023) begin : g_bad_param
    $error("uart_cmd_decoder: parameter exceeds 10-bit range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_XH, S_XL, S_YH, S_YL
  } state_t;

  state_t r_state, w_state_eff, w_state_nxt;

  logic [CW-1:0] r_cnt;
  logic [9:0] r_px, r_py, w_px_nxt, w_py_nxt;
  logic [9:0] r_obj_x, r_obj_y;
  logic [1:0] r_xh, r_yh;
  logic [7:0] r_xl;
  logic r_busy, r_err, w_tmo;

  logic [9:0] w_x_raw, w_y_raw;
  logic [9:0] w_x_up, w_x_dn, w_y_up, w_y_dn;
  logic [9:0] w_x_abs, w_y_abs;

  // Final packet byte is still on rx_data when the load happens.
  assign w_x_raw = {r_xh, r_xl};
  assign w_y_raw = {r_yh, rx_data};

`ifdef CMD_CLAMP_EN
  localparam logic [9:0] LP_XM = 10'(X_MAX);
  localparam logic [9:0] LP_YM = 10'(Y_MAX);
  logic [10:0] w_xs, w_ys;

  assign w_xs = {1'b0, r_px} + {1'b0, LP_STEP};
  assign w_ys = {1'b0, r_py} + {1'b0, LP_STEP};
  assign w_x_up = (w_xs > {1'b0, LP_XM}) ? LP_XM : w_xs[9:0];
  assign w_y_up = (w_ys > {1'b0, LP_YM}) ? LP_YM : w_ys[9:0];
  assign w_x_dn = (r_px < LP_STEP) ? '0 : r_px - LP_STEP;
  assign w_y_dn = (r_py < LP_STEP) ? '0 : r_py - LP_STEP;
  assign w_x_abs = (w_x_raw > LP_XM) ? LP_XM : w_x_raw;
  assign w_y_abs = (w_y_raw > LP_YM) ? LP_YM : w_y_raw;
`else
  assign w_x_up = r_px + LP_STEP;
  assign w_y_up = r_py + LP_STEP;
  assign w_x_dn = r_px - LP_STEP;
  assign w_y_dn = r_py - LP_STEP;
  assign w_x_abs = w_x_raw;
  assign w_y_abs = w_y_raw;
`endif

  always_comb begin
    w_tmo = (r_state != S_IDLE) && (r_cnt == LP_TMO);
    // A byte landing on the timeout cycle is parsed as an IDLE byte.
    w_state_eff = w_tmo ? S_IDLE : r_state;
    w_state_nxt = w_state_eff;
    w_px_nxt = r_px;
    w_py_nxt = r_py;
    if (rx_valid) begin
      case (w_state_eff)
        S_IDLE: begin
          case (rx_data)
            8'h77: w_py_nxt = w_y_dn;
            8'h73: w_py_nxt = w_y_up;
            8'h61: w_px_nxt = w_x_dn;
            8'h64: w_px_nxt = w_x_up;
            8'h68: begin
              w_px_nxt = LP_XI;
              w_py_nxt = LP_YI;
            end
            8'h50: w_state_nxt = S_XH;
            default: ;
          endcase
        end
        S_XH: w_state_nxt = S_XL;
        S_XL: w_state_nxt = S_YH;
        S_YH: w_state_nxt = S_YL;
        S_YL: begin
          w_px_nxt = w_x_abs;
          w_py_nxt = w_y_abs;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_px <= LP_XI;
      r_py <= LP_YI;
      r_obj_x <= LP_XI;
      r_obj_y <= LP_YI;
      r_xh <= '0;
      r_xl <= '0;
      r_yh <= '0;
      r_busy <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_px <= w_px_nxt;
      r_py <= w_py_nxt;
      if (rx_valid || w_tmo || r_state == S_IDLE)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      // Publish the pre-byte position; this cycle's byte shows next frame.
      if (frame_start) begin
        r_obj_x <= r_px;
        r_obj_y <= r_py;
      end
      if (rx_valid) begin
        case (w_state_eff)
          S_XH: r_xh <= rx_data[1:0];
          S_XL: r_xl <= rx_data;
          S_YH: r_yh <= rx_data[1:0];
          default: ;
        endcase
      end
      r_busy <= (w_state_nxt != S_IDLE);
      r_err <= w_tmo;
    end
  end

  assign obj_x = r_obj_x;
  assign obj_y = r_obj_y;
  assign busy = r_busy;
  assign cmd_err = r_err;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed scenarios plus random byte traffic,
// every cycle compared against a queue-based behavioural model.
module tb_uart_cmd_decoder;

  localparam int STEP = 4;
  localparam int XI = 320;
  localparam int YI = 240;
  localparam int XM = 539;
  localparam int YM = 379;
  localparam int TO = 40;

`ifdef CMD_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [7:0] rx_data;
  logic rx_valid;
  logic frame_start;
  logic [9:0] obj_x, obj_y;
  logic busy, cmd_err;

  int passed = 0;
  int failed = 0;
  int total = 0;

  always #5 clk = ~clk;

  uart_cmd_decoder #(
    .STEP(STEP), .X_INIT(XI), .Y_INIT(YI),
    .X_MAX(XM), .Y_MAX(YM), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_start(frame_start),
    .obj_x(obj_x),
    .obj_y(obj_y),
    .busy(busy),
    .cmd_err(cmd_err)
  );

  // Reference model state
  int mx, my, mox, moy, idle;
  bit mbusy, merr, in_pkt;
  logic [7:0] pkt[$];

  function automatic int mv(int v, int d, int m);
    int r;
    r = v + d;
    if (CLAMP) begin
      if (r < 0) r = 0;
      if (r > m) r = m;
    end else begin
      r = (r + 1024) % 1024;
    end
    return r;
  endfunction

  function automatic int ab(int v, int m);
    if (CLAMP && v > m) return m;
    return v;
  endfunction

  task automatic model_step(bit rst, bit v, logic [7:0] d, bit fs);
    bit was, tmo;
    if (rst) begin
      mx = XI; my = YI; mox = XI; moy = YI;
      in_pkt = 0; idle = 0; mbusy = 0; merr = 0;
      pkt.delete();
    end else begin
      was = in_pkt;
      if (fs) begin
        mox = mx;
        moy = my;
      end
      tmo = in_pkt && (idle == TO - 1);
      merr = tmo;
      if (tmo) begin
        in_pkt = 0;
        pkt.delete();
      end
      if (v) begin
        if (in_pkt) begin
          pkt.push_back(d);
          if (pkt.size() == 4) begin
            mx = ab(int'(pkt[0] & 8'h03) * 256 + int'(pkt[1]), XM);
            my = ab(int'(pkt[2] & 8'h03) * 256 + int'(pkt[3]), YM);
            in_pkt = 0;
            pkt.delete();
          end
        end else begin
          case (d)
            8'h77: my = mv(my, -STEP, YM);
            8'h73: my = mv(my, STEP, YM);
            8'h61: mx = mv(mx, -STEP, XM);
            8'h64: mx = mv(mx, STEP, XM);
            8'h68: begin mx = XI; my = YI; end
            8'h50: in_pkt = 1;
            default: ;
          endcase
        end
      end
      idle = (v || !was || tmo) ? 0 : idle + 1;
      mbusy = in_pkt;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(bit rst, bit v, logic [7:0] d, bit fs);
    reset = rst;
    rx_valid = v;
    rx_data = v ? d : 8'($urandom);
    frame_start = fs;
    @(posedge clk);
    model_step(rst, v, d, fs);
    #1;
    chk("obj_x", 32'(obj_x), 32'(mox));
    chk("obj_y", 32'(obj_y), 32'(moy));
    chk("busy", 32'(busy), 32'(mbusy));
    chk("cmd_err", 32'(cmd_err), 32'(merr));
  endtask

  task automatic send(logic [7:0] b);
    cyc(1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic gap(int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic frame();
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic packet(int x, int y);
    send(8'h50);
    send(8'(x >> 8));
    send(8'(x));
    send(8'(y >> 8));
    send(8'(y));
  endtask

  initial begin
    int hit, pulses;
    logic [7:0] b;
    int r;

    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_x", 32'(obj_x), 32'd320);
    chk("rst_y", 32'(obj_y), 32'd240);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);

    // 1: single move, display waits for frame_start
    send(8'h64);
    gap(2);
    chk("t1_pre_x", 32'(obj_x), 32'd320);
    frame();
    chk("t1_x", 32'(obj_x), 32'd324);
    chk("t1_y", 32'(obj_y), 32'd240);

    // 2: back-to-back absolute packet
    send(8'h50);
    chk("t2_busy1", 32'(busy), 32'd1);
    send(8'h01);
    send(8'h2C);
    send(8'h00);
    chk("t2_busy4", 32'(busy), 32'd1);
    send(8'h64);
    chk("t2_busy5", 32'(busy), 32'd0);
    frame();
    chk("t2_x", 32'(obj_x), 32'd300);
    chk("t2_y", 32'(obj_y), 32'd100);

    // 3: timeout
    send(8'h68);
    frame();
    send(8'h50);
    send(8'h01);
    hit = -1;
    pulses = 0;
    for (int k = 1; k <= TO + 10; k++) begin
      gap(1);
      if (cmd_err === 1'b1) begin
        pulses++;
        if (hit < 0) hit = k;
      end
    end
    chk("t3_err_at", 32'(hit), 32'(TO));
    chk("t3_pulses", 32'(pulses), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    send(8'h61);
    frame();
    chk("t3_x", 32'(obj_x), 32'd316);
    chk("t3_y", 32'(obj_y), 32'd240);

    // 4: underflow behaviour
    packet(0, 0);
    send(8'h61);
    send(8'h77);
    frame();
    chk("t4_x", 32'(obj_x), CLAMP ? 32'd0 : 32'd1020);
    chk("t4_y", 32'(obj_y), CLAMP ? 32'd0 : 32'd1020);

    // 5: byte and frame_start together
    send(8'h68);
    frame();
    cyc(1'b0, 1'b1, 8'h73, 1'b1);
    chk("t5_same", 32'(obj_y), 32'd240);
    frame();
    chk("t5_next", 32'(obj_y), 32'd244);

    // 6: reset mid-packet
    send(8'h50);
    send(8'h02);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_x", 32'(obj_x), 32'd320);
    chk("t6_y", 32'(obj_y), 32'd240);
    packet(10, 20);
    frame();
    chk("t6_px", 32'(obj_x), 32'd10);
    chk("t6_py", 32'(obj_y), 32'd20);

    // Overflow past the max on a packet load
    packet(1023, 1023);
    frame();
    chk("big_x", 32'(obj_x), CLAMP ? 32'(XM) : 32'd1023);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        repeat ($urandom_range(30, 50))
          cyc(1'b0, 1'b0, 8'h00, $urandom_range(0, 9) == 0);
      end else if (r == 99) begin
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
      end else begin
        case ($urandom_range(0, 7))
          0: b = 8'h77;
          1: b = 8'h73;
          2: b = 8'h61;
          3: b = 8'h64;
          4: b = 8'h68;
          5: b = 8'h50;
          default: b = 8'($urandom);
        endcase
        cyc(1'b0, r < 75, b, $urandom_range(0, 7) == 0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

- Sits between the UART receiver and the sprite/object renderer.
- Consumes received bytes and parses single-key move commands and a 5-byte absolute-position packet.
- Keeps a pending object position, with a timeout-guarded packet FSM.
- Publishes the position to the renderer only on a frame-start pulse, so the object never tears mid-frame.

## Interface

Parameters:
- STEP, 4: pixel displacement per move command.
- X_INIT, 320: reset/home X coordinate.
- Y_INIT, 240: reset/home Y coordinate.
- X_MAX, 539: largest legal X (640 − 100 − 1).
- Y_MAX, 379: largest legal Y (480 − 100 − 1).
- TIMEOUT, 1000000: idle cycles allowed between packet bytes.

Ports:
- clk  in  1  clock clk.
- reset  in  1  reset reset, synchronous, active-high.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one byte per pulse.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- obj_x  out  10  displayed X; reset X_INIT.
- obj_y  out  10  displayed Y; reset Y_INIT.
- busy  out  1  high while a position packet is in progress; reset 0.
- cmd_err  out  1  one-cycle pulse on packet timeout; reset 0.

## Operation

- Internal pending registers px/py reset to X_INIT/Y_INIT.
- On each frame_start, obj_x/obj_y load px/py.
- FSM states: IDLE, XH, XL, YH, YL. Reset state is IDLE.
- IDLE, byte accepted on rx_valid:
  - 0x77 'w': py −= STEP.
  - 0x73 's': py += STEP.
  - 0x61 'a': px −= STEP.
  - 0x64 'd': px += STEP.
  - 0x68 'h': px = X_INIT, py = Y_INIT.
  - 0x50 'P': go to XH, busy=1.
  - Any other byte: ignored.
- Packet path: XH stores byte → XL → YH → YL.
  - On the YL byte: px = {xh[1:0], xl}, py = {yh[1:0], yl}; return to IDLE; busy=0.
  - Upper 6 bits of xh/yh are ignored.
  - Move letters inside a packet are treated as data bytes, not commands.
- Timeout:
  - A cycle counter clears on every accepted byte and counts only outside IDLE.
  - When it reaches TIMEOUT−1 with no byte: return to IDLE, pulse cmd_err for 1 cycle.
  - px/py are unchanged.
- Arithmetic is 10-bit unsigned. Wrap vs clamp behaviour is set under Configuration.
- Reset mid-packet: FSM goes to IDLE, counter is cleared, px/py/obj return to INIT values.
  - No cmd_err pulse.
  - Partial bytes are discarded.

## Timing

- A byte accepted at edge n updates px/py and the FSM state at edge n+1.
- obj_x/obj_y change only at the edge where frame_start=1. Latency from byte to display is at most one frame.
- If rx_valid and frame_start are high in the same cycle:
  - obj takes the pre-byte px/py.
  - The byte's effect appears at the next frame_start.
- A byte that arrives in the same cycle the timeout fires is accepted and handled as an IDLE byte. cmd_err still pulses.
- Back-to-back rx_valid on consecutive cycles must be supported, with no byte lost.
- busy:
  - rises the cycle after 'P' is accepted.
  - falls the cycle after YL is accepted or the timeout fires.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration

Feature macro: CMD_CLAMP_EN.
- Defined:
  - Moves saturate: px in [0, X_MAX], py in [0, Y_MAX]. A decrement below 0 gives 0; an increment past the max gives the max.
  - Absolute packet values above the max load the max.
- Undefined:
  - Moves wrap modulo 1024.
  - Absolute values load unmodified, 0–1023.
- Each build compiles exactly one of these behaviours. The port list is identical in both.

## Test plan

1. Reset, then send 'd' and pulse frame_start → obj_x=324, obj_y=240. Before frame_start, obj_x is still 320.
2. Send packet 0x50,0x01,0x2C,0x00,0x64, then frame_start → obj_x=300, obj_y=100. busy is high from byte 1 through byte 5.
3. Send 0x50,0x01 and wait TIMEOUT cycles → one-cycle cmd_err pulse, busy=0, position unchanged. A following 'a' then frame_start gives obj_x=316.
4. Clamp test: send packet x=0, y=0, then 'a' and 'w', then frame_start.
   - With CMD_CLAMP_EN: obj=(0,0).
   - Without CMD_CLAMP_EN: obj=(1020,1020).
5. Assert 's' and frame_start in the same cycle → obj_y stays 240 on that frame and becomes 244 on the next frame_start.
6. Assert reset after 'P',0x02 → busy=0, obj=(320,240). A following complete packet x=10, y=20 displays (10,20).
